salamander_rom_loader: RTL and testbench

Sits between `hps_io` and the Salamander game board as the ROM and DIP download front end. It packs the byte stream from the `ioctl` interface into 16-bit big-endian words and issues them as SDRAM write requests using a req/ack handshake. It holds `ioctl_wait` high while a word is in flight. It also captures the DIP-switch download and generates a board-hold signal until the ROM image is complete.

---
 rtl/salamander_rom_loader_if.sv | 26 ++
 rtl/salamander_rom_loader.sv | 195 +++++++++++++++++++
 tb/tb_salamander_rom_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/salamander_rom_loader_if.sv
// Byte-stream download bus from hps_io plus the SDRAM write request channel.
// The slave side is the ROM loader; the master side is hps_io and the SDRAM controller.
interface salamander_rom_loader_if #(
    parameter int ADDR_W = 22
);
    logic [15:0]       ioctl_index;
    logic              ioctl_download;
    logic [26:0]       ioctl_addr;
    logic [7:0]        ioctl_data;
    logic              ioctl_wr;
    logic              ioctl_wait;
    logic              o_SDRAM_WR_REQ;
    logic [ADDR_W-1:0] o_SDRAM_WR_ADDR;
    logic [15:0]       o_SDRAM_WR_DATA;
    logic              i_SDRAM_WR_ACK;

    modport slave (
        input  ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_WR_ACK,
        output ioctl_wait, o_SDRAM_WR_REQ, o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA
    );

    modport master (
        output ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_WR_ACK,
        input  ioctl_wait, o_SDRAM_WR_REQ, o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA
    );
endinterface

// File: rtl/salamander_rom_loader.sv
// ROM/DIP download front end: packs ioctl bytes into big-endian 16-bit SDRAM writes,
// captures DIP bytes and holds the board until the ROM image is complete.
module salamander_rom_loader #(
    parameter logic [15:0] ROM_INDEX   = 16'd0,
    parameter logic [15:0] DIP_INDEX   = 16'd254,
    parameter int          ADDR_W      = 22,
    parameter logic [23:0] DIP_DEFAULT = 24'hFFFFFF
) (
    input  logic                     i_EMU_MCLK,
    input  logic                     i_EMU_INITRST,
    salamander_rom_loader_if.slave   bus,
    output logic [23:0]              o_DIPSW,
    output logic                     o_ROM_READY,
    output logic                     o_BOARD_HOLD,
    output logic                     o_OVERFLOW
);
    typedef enum logic [1:0] {IDLE = 2'd0, HALF = 2'd1, REQ = 2'd2, FLUSH = 2'd3} state_t;

    state_t            state_r, state_n;
    logic [7:0]        hi_r;
    logic [ADDR_W-1:0] addr_r;
    logic              held_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [15:0]       wr_data_r;
    logic              req_r, wait_r;
    logic              dl_r, pending_r, ready_r, hold_r, ovf_r;
    logic [23:0]       dip_r;

    logic              rom_byte_s, in_window_s, ok_byte_s, dip_wr_s;
    logic              stage_s, word_s, held_set_s, held_clr_s, proto_err_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [15:0]       word_data_s;
    logic              rom_start_s, ready_set_s, ready_n;

    assign rom_byte_s  = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
    assign in_window_s = ~|(bus.ioctl_addr >> (ADDR_W + 1));
    assign ok_byte_s   = rom_byte_s & in_window_s;
    assign dip_wr_s    = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == DIP_INDEX)
                         & (bus.ioctl_addr < 27'd3);
    assign rom_start_s = bus.ioctl_download & ~dl_r & (bus.ioctl_index == ROM_INDEX);

    // Next-state and word-formation decisions of the packing FSM.
    always_comb begin
        state_n     = state_r;
        stage_s     = 1'b0;
        word_s      = 1'b0;
        held_set_s  = 1'b0;
        held_clr_s  = 1'b0;
        proto_err_s = 1'b0;
        word_addr_s = addr_r;
        word_data_s = {hi_r, 8'hFF};
        case (state_r)
            IDLE: begin
                if (ok_byte_s && bus.ioctl_addr[0]) begin
                    word_s      = 1'b1;
                    word_addr_s = bus.ioctl_addr[ADDR_W:1];
                    word_data_s = {8'hFF, bus.ioctl_data};
                    state_n     = REQ;
                end else if (ok_byte_s) begin
                    stage_s = 1'b1;
                    state_n = HALF;
                end else begin
                    state_n = IDLE;
                end
            end
            HALF: begin
                if (ok_byte_s && bus.ioctl_addr[0]) begin
                    word_s      = 1'b1;
                    word_data_s = {hi_r, bus.ioctl_data};
                    state_n     = REQ;
                end else if (ok_byte_s) begin
                    // Previous word is incomplete: send it padded, keep the new byte staged.
                    word_s     = 1'b1;
                    stage_s    = 1'b1;
                    held_set_s = 1'b1;
                    state_n    = REQ;
                end else if (!bus.ioctl_download) begin
                    state_n = FLUSH;
                end else begin
                    state_n = HALF;
                end
            end
            REQ: begin
                proto_err_s = rom_byte_s;
                if (bus.i_SDRAM_WR_ACK && held_r) begin
                    held_clr_s = 1'b1;
                    state_n    = HALF;
                end else if (bus.i_SDRAM_WR_ACK) begin
                    state_n = IDLE;
                end else begin
                    state_n = REQ;
                end
            end
            FLUSH: begin
                proto_err_s = rom_byte_s;
                word_s      = 1'b1;
                state_n     = REQ;
            end
            default: state_n = IDLE;
        endcase
    end

    // READY sets only once a started ROM download has ended and the FSM is drained.
    always_comb begin
        ready_set_s = pending_r & ~dl_r & ~bus.ioctl_download & (state_r == IDLE);
        if (rom_start_s) begin
            ready_n = 1'b0;
        end else if (ready_set_s) begin
            ready_n = 1'b1;
        end else begin
            ready_n = ready_r;
        end
    end

    // FSM state register.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Staged even byte, pending SDRAM word and handshake outputs.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            hi_r      <= 8'h00;
            addr_r    <= '0;
            held_r    <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 16'h0000;
            req_r     <= 1'b0;
            wait_r    <= 1'b0;
        end else begin
            if (stage_s) begin
                hi_r   <= bus.ioctl_data;
                addr_r <= bus.ioctl_addr[ADDR_W:1];
            end
            if (held_set_s) begin
                held_r <= 1'b1;
            end else if (held_clr_s) begin
                held_r <= 1'b0;
            end
            if (word_s) begin
                wr_addr_r <= word_addr_s;
                wr_data_r <= word_data_s;
            end
            req_r  <= (state_n == REQ);
            wait_r <= (state_n == REQ) || (state_n == FLUSH);
        end
    end

    // Download tracking, DIP capture, ready/hold and sticky overflow.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            dl_r      <= 1'b0;
            pending_r <= 1'b0;
            ready_r   <= 1'b0;
            hold_r    <= 1'b1;
            ovf_r     <= 1'b0;
            dip_r     <= DIP_DEFAULT;
        end else begin
            dl_r    <= bus.ioctl_download;
            ready_r <= ready_n;
            hold_r  <= ~ready_n;
            if (rom_start_s) begin
                pending_r <= 1'b1;
            end else if (ready_set_s) begin
                pending_r <= 1'b0;
            end
            if ((rom_byte_s && !in_window_s) || proto_err_s) begin
                ovf_r <= 1'b1;
            end else if (rom_start_s) begin
                ovf_r <= 1'b0;
            end
            if (dip_wr_s) begin
                case (bus.ioctl_addr[1:0])
                    2'd0:    dip_r[7:0]   <= bus.ioctl_data;
                    2'd1:    dip_r[15:8]  <= bus.ioctl_data;
                    2'd2:    dip_r[23:16] <= bus.ioctl_data;
                    default: dip_r        <= dip_r;
                endcase
            end
        end
    end

    assign bus.ioctl_wait      = wait_r;
    assign bus.o_SDRAM_WR_REQ  = req_r;
    assign bus.o_SDRAM_WR_ADDR = wr_addr_r;
    assign bus.o_SDRAM_WR_DATA = wr_data_r;
    assign o_DIPSW             = dip_r;
    assign o_ROM_READY         = ready_r;
    assign o_BOARD_HOLD        = hold_r;
    assign o_OVERFLOW          = ovf_r;
endmodule

// File: tb/tb_salamander_rom_loader.sv
// Bench for salamander_rom_loader: directed scenarios plus randomized downloads
// checked against a per-word expectation built from the byte list.
module tb_salamander_rom_loader;
    logic        clk;
    logic        rst;
    logic [23:0] dipsw;
    logic        rom_ready, board_hold, overflow;

    salamander_rom_loader_if #(.ADDR_W(22)) bus ();

    salamander_rom_loader #(.ADDR_W(22)) dut (
        .i_EMU_MCLK    (clk),
        .i_EMU_INITRST (rst),
        .bus           (bus),
        .o_DIPSW       (dipsw),
        .o_ROM_READY   (rom_ready),
        .o_BOARD_HOLD  (board_hold),
        .o_OVERFLOW    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [37:0] wq[$];
    int  ack_delay = 2;
    bit  ack_en    = 1'b1;
    bit  mon_en    = 1'b0;
    int  mon_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // SDRAM side: acknowledge after ack_delay cycles and log accepted words.
    initial begin
        int cnt;
        cnt = 0;
        bus.i_SDRAM_WR_ACK = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_SDRAM_WR_ACK = 1'b0;
            if (mon_en && (bus.ioctl_wait !== bus.o_SDRAM_WR_REQ)) mon_bad++;
            if (!rst && bus.o_SDRAM_WR_REQ && ack_en) begin
                if (cnt >= ack_delay) begin
                    bus.i_SDRAM_WR_ACK = 1'b1;
                    wq.push_back({bus.o_SDRAM_WR_ADDR, bus.o_SDRAM_WR_DATA});
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic start_dl(input logic [15:0] idx);
        @(negedge clk);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl();
        @(negedge clk);
        bus.ioctl_download = 1'b0;
    endtask

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ioctl_wait && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_val("wait_timeout", 32'd1, 32'd0);
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        @(negedge clk);
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int c;
        c = 0;
        while ((wq.size() < n || bus.ioctl_wait) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) check_val("write_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!rom_ready && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) check_val("ready_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [37:0] exp_q[$];
        logic [26:0] ba[$];
        logic [7:0]  bd[$];
        logic [37:0] w;
        logic [21:0] a0;
        logic [15:0] d0;
        int early, unstable, nw, w0, pat;
        bit half;
        logic [7:0] e, o;

        rst = 1'b1;
        bus.ioctl_index = 16'd0; bus.ioctl_download = 1'b0;
        bus.ioctl_addr = 27'd0; bus.ioctl_data = 8'd0; bus.ioctl_wr = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req",   {31'd0, bus.o_SDRAM_WR_REQ}, 32'd0);
        check_val("rst_wait",  {31'd0, bus.ioctl_wait}, 32'd0);
        check_val("rst_addr",  {10'd0, bus.o_SDRAM_WR_ADDR}, 32'd0);
        check_val("rst_data",  {16'd0, bus.o_SDRAM_WR_DATA}, 32'd0);
        check_val("rst_dip",   {8'd0, dipsw}, 32'h00FFFFFF);
        check_val("rst_ready", {31'd0, rom_ready}, 32'd0);
        check_val("rst_hold",  {31'd0, board_hold}, 32'd1);
        check_val("rst_ovf",   {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // Four-byte ROM, ack two cycles into REQ.
        wq.delete();
        ack_delay = 2;
        mon_en = 1'b1;
        start_dl(16'd0);
        send_byte(27'd0, 8'h12);
        send_byte(27'd1, 8'h34);
        send_byte(27'd2, 8'h56);
        send_byte(27'd3, 8'h78);
        wait_writes(2);
        end_dl();
        @(negedge clk);
        check_val("t1_ready_early", {31'd0, rom_ready}, 32'd0);
        @(negedge clk);
        check_val("t1_ready", {31'd0, rom_ready}, 32'd1);
        check_val("t1_hold",  {31'd0, board_hold}, 32'd0);
        mon_en = 1'b0;
        check_val("t1_wait_vs_req", mon_bad, 32'd0);
        check_val("t1_count", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            check_val("t1_w0", {26'd0, wq[0][37:16]}, 32'd0);
            check_val("t1_d0", {16'd0, wq[0][15:0]}, 32'h1234);
            check_val("t1_w1", {26'd0, wq[1][37:16]}, 32'd1);
            check_val("t1_d1", {16'd0, wq[1][15:0]}, 32'h5678);
        end

        // Three-byte ROM, odd tail goes out through FLUSH.
        wq.delete();
        ack_delay = 4;
        start_dl(16'd0);
        check_val("t2_ready_clr", {31'd0, rom_ready}, 32'd0);
        send_byte(27'd0, 8'hAA);
        send_byte(27'd1, 8'hBB);
        send_byte(27'd2, 8'hCC);
        end_dl();
        early = 0;
        for (int i = 0; i < 200 && wq.size() < 2; i++) begin
            @(negedge clk);
            if (rom_ready) early++;
        end
        check_val("t2_ready_early", early, 32'd0);
        wait_ready();
        check_val("t2_ready", {31'd0, rom_ready}, 32'd1);
        check_val("t2_count", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            check_val("t2_d0", {16'd0, wq[0][15:0]}, 32'hAABB);
            check_val("t2_w1", {26'd0, wq[1][37:16]}, 32'd1);
            check_val("t2_d1", {16'd0, wq[1][15:0]}, 32'hCCFF);
        end

        // DIP download: no SDRAM traffic, READY untouched.
        wq.delete();
        start_dl(16'd254);
        send_byte(27'd0, 8'h01);
        send_byte(27'd1, 8'h02);
        send_byte(27'd2, 8'h03);
        send_byte(27'd3, 8'h04);
        end_dl();
        repeat (4) @(negedge clk);
        check_val("dip_val",   {8'd0, dipsw}, 32'h00030201);
        check_val("dip_nowr",  wq.size(), 32'd0);
        check_val("dip_ready", {31'd0, rom_ready}, 32'd1);

        // Randomized ROM downloads with gaps, odd starts and odd tails.
        for (int it = 0; it < 10; it++) begin
            wq.delete(); exp_q.delete(); ba.delete(); bd.delete();
            ack_delay = $urandom_range(0, 4);
            nw = $urandom_range(1, 6);
            w0 = $urandom_range(0, 20);
            half = 1'b0;
            for (int k = 0; k < nw; k++) begin
                pat = $urandom_range(0, 3);
                if (pat == 2 && half) pat = 0;
                e = 8'($urandom);
                o = 8'($urandom);
                if (pat == 0 || pat == 1) begin ba.push_back(27'(2*(w0+k)));   bd.push_back(e); end
                if (pat == 0 || pat == 2) begin ba.push_back(27'(2*(w0+k)+1)); bd.push_back(o); end
                if (pat != 3)
                    exp_q.push_back({22'(w0+k), (pat == 2) ? 8'hFF : e, (pat == 1) ? 8'hFF : o});
                if (pat != 3) half = (pat == 1);
            end
            if (ba.size() == 0) begin
                e = 8'($urandom); o = 8'($urandom);
                ba.push_back(27'(2*w0)); bd.push_back(e);
                ba.push_back(27'(2*w0+1)); bd.push_back(o);
                exp_q.push_back({22'(w0), e, o});
            end
            start_dl(16'd0);
            check_val("rnd_ready_clr", {31'd0, rom_ready}, 32'd0);
            for (int b = 0; b < ba.size(); b++) send_byte(ba[b], bd[b]);
            end_dl();
            wait_ready();
            check_val("rnd_count", wq.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < wq.size(); j++) begin
                check_val("rnd_addr", {26'd0, wq[j][37:16]}, {26'd0, exp_q[j][37:16]});
                check_val("rnd_data", {16'd0, wq[j][15:0]}, {16'd0, exp_q[j][15:0]});
            end
            check_val("rnd_ovf", {31'd0, overflow}, 32'd0);
        end

        // Byte beyond the ROM window.
        wq.delete();
        ack_delay = 1;
        start_dl(16'd0);
        send_byte(27'h0800000, 8'h5A);
        end_dl();
        repeat (4) @(negedge clk);
        check_val("ovf_nowr", wq.size(), 32'd0);
        check_val("ovf_set",  {31'd0, overflow}, 32'd1);
        start_dl(16'd254);
        end_dl();
        repeat (2) @(negedge clk);
        check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
        start_dl(16'd0);
        check_val("ovf_clr", {31'd0, overflow}, 32'd0);
        end_dl();
        repeat (4) @(negedge clk);

        // Ack withheld for 100 cycles with an illegal byte during REQ.
        ack_en = 1'b0;
        start_dl(16'd0);
        send_byte(27'd8, 8'h9A);
        send_byte(27'd9, 8'hBC);
        check_val("hold_req", {31'd0, bus.o_SDRAM_WR_REQ}, 32'd1);
        a0 = bus.o_SDRAM_WR_ADDR;
        d0 = bus.o_SDRAM_WR_DATA;
        check_val("hold_word", {16'd0, d0}, 32'h9ABC);
        unstable = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.ioctl_wr = 1'b0;
            if (i == 10) begin
                bus.ioctl_addr = 27'd10;
                bus.ioctl_data = 8'h55;
                bus.ioctl_wr   = 1'b1;
            end
            if (bus.o_SDRAM_WR_REQ !== 1'b1 || bus.ioctl_wait !== 1'b1 ||
                bus.o_SDRAM_WR_ADDR !== a0 || bus.o_SDRAM_WR_DATA !== d0) unstable++;
        end
        bus.ioctl_wr = 1'b0;
        check_val("hold_stable", unstable, 32'd0);
        check_val("hold_ovf", {31'd0, overflow}, 32'd1);

        // Asynchronous reset while the request is still pending.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_req",  {31'd0, bus.o_SDRAM_WR_REQ}, 32'd0);
        check_val("arst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        check_val("arst_dip",  {8'd0, dipsw}, 32'h00FFFFFF);
        check_val("arst_hold", {31'd0, board_hold}, 32'd1);
        check_val("arst_ovf",  {31'd0, overflow}, 32'd0);
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
